// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one MMU translation path and the external memory bus
// between instruction fetch (I) and data access (D). D has fixed priority.
// Each access is translated once, latched, then run on the bus to completion.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        i_req,
    input  logic [31:0] i_vaddr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_vaddr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_err,
    output logic [31:0] mmu_vaddr,
    input  logic [31:0] mmu_paddr,
    input  logic        mmu_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_o,
    output logic        bus_timeout_o
);

    typedef enum logic [1:0] {IDLE, BUS, FAULT, DONE} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("mem_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t      state, state_nxt;
    owner_t      owner;
    logic [31:0] vaddr_q, paddr_q, wdata_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] i_rdata_q, d_rdata_q;
    logic        mem_req_q;
    logic        grant;
    logic        tmo_expire;

    assign grant = (state == IDLE) && (i_req || d_req);

    // MMU sees the live requester in IDLE, the latched address otherwise
    assign mmu_vaddr = (state == IDLE) ? (d_req ? d_vaddr : i_vaddr) : vaddr_q;

`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;
    logic        tmo_flag;

    // Expiry on the last allowed BUS cycle; a same-cycle ack takes precedence
    assign tmo_expire = (state == BUS) && !mem_ack && (tmo_cnt == TMO_LAST);

    // Wait counter held at zero outside BUS so it starts cleared on entry
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            tmo_flag <= tmo_expire;
            if (state != BUS)
                tmo_cnt <= '0;
            else if (!mem_ack)
                tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign bus_timeout_o = tmo_flag;
`else
    assign tmo_expire    = 1'b0;
    assign bus_timeout_o = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (i_req || d_req) state_nxt = mmu_error ? FAULT : BUS;
            BUS: begin
                if (mem_ack)         state_nxt = DONE;
                else if (tmo_expire) state_nxt = FAULT;
            end
            FAULT: state_nxt = IDLE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; mem_req is its own flop so the bus sees a clean request
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_req_q <= (state_nxt == BUS);
        end
    end

    // Capture owner, translation and write payload once at grant
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            owner   <= OWN_I;
            vaddr_q <= '0;
            paddr_q <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            owner   <= d_req ? OWN_D : OWN_I;
            vaddr_q <= mmu_vaddr;
            paddr_q <= mmu_paddr;
            we_q    <= d_req & d_we;
            be_q    <= d_req ? d_be : 4'b1111;
            wdata_q <= d_req ? d_wdata : '0;
        end
    end

    // Read data registers; updated only by an acknowledged bus cycle
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else if (state == BUS && mem_ack) begin
            if (owner == OWN_D) d_rdata_q <= mem_rdata;
            else                i_rdata_q <= mem_rdata;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_addr  = paddr_q;
    assign mem_wdata = wdata_q;

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ready = (state == DONE || state == FAULT) && (owner == OWN_I);
    assign d_ready = (state == DONE || state == FAULT) && (owner == OWN_D);
    assign i_err   = (state == FAULT) && (owner == OWN_I);
    assign d_err   = (state == FAULT) && (owner == OWN_D);

    assign stall_o = (i_req & ~i_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: MMU modelled as a fixed offset with a
// faulting page at 0xF0000000, memory bus slave with programmable wait states.
// Timeout scenarios compile in when MEM_TIMEOUT_EN is defined.
module tb_mem_arbiter;

    localparam logic [31:0] MAP = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        clr;
    logic        i_req, d_req, d_we;
    logic [31:0] i_vaddr, d_vaddr, d_wdata;
    logic [3:0]  d_be;
    logic [31:0] i_rdata, d_rdata;
    logic        i_ready, i_err, d_ready, d_err;
    logic [31:0] mmu_vaddr, mmu_paddr;
    logic        mmu_error;
    logic        mem_req, mem_we, mem_ack;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_o, bus_timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] map_offset = MAP;
    int          ack_wait = 0;
    bit          no_ack = 1'b0;
    logic [31:0] bus_rdata_val = 32'h0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;
    bus_t bus_log[$];

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .clr(clr),
        .i_req(i_req), .i_vaddr(i_vaddr), .i_rdata(i_rdata), .i_ready(i_ready), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_vaddr(d_vaddr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
        .mmu_vaddr(mmu_vaddr), .mmu_paddr(mmu_paddr), .mmu_error(mmu_error),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_o(stall_o), .bus_timeout_o(bus_timeout_o)
    );

    // MMU model: linear offset, top page faults
    assign mmu_paddr = mmu_vaddr + map_offset;
    assign mmu_error = (mmu_vaddr[31:28] == 4'hF);

    // Bus slave: acks after ack_wait idle BUS cycles, logs each completed transfer
    initial begin
        int bcnt;
        bcnt      = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (!no_ack && bcnt == ack_wait) begin
                    mem_ack   = 1'b1;
                    mem_rdata = bus_rdata_val;
                    bus_log.push_back('{mem_addr, mem_we, mem_be, mem_wdata});
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = ~bus_rdata_val;
                    bcnt++;
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'h0;
                bcnt      = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the requested sides from cycle 0 (caller positioned just after an
    // edge with the DUT idle), drops each request after its ready, and reports
    // what happened. Cycle indices are -1 when no ready was seen.
    task automatic run_access(input bit ir, input bit dr, input int maxc,
                              output int ti, output int td,
                              output logic ei, output logic ed,
                              output logic [31:0] ri, output logic [31:0] rd,
                              output int nreq, output int stall_bad,
                              output int spur, output int ntmo, output logic tmo_d);
        bit ia, da;
        logic exp_stall;
        ia = ir; da = dr;
        ti = -1; td = -1; ei = 1'bx; ed = 1'bx; ri = 'x; rd = 'x; tmo_d = 1'bx;
        nreq = 0; stall_bad = 0; spur = 0; ntmo = 0;
        i_req = ia; d_req = da;
        for (int c = 0; c < maxc && (ia || da); c++) begin
            @(negedge clk);
            exp_stall = (ia & ~i_ready) | (da & ~d_ready);
            if (stall_o !== exp_stall) stall_bad++;
            if (mem_req === 1'b1) nreq++;
            if (bus_timeout_o === 1'b1) ntmo++;
            if (i_ready === 1'b1) begin
                if (ia) begin ti = c; ei = i_err; ri = i_rdata; ia = 1'b0; end
                else spur++;
            end
            if (d_ready === 1'b1) begin
                if (da) begin td = c; ed = d_err; rd = d_rdata; tmo_d = bus_timeout_o; da = 1'b0; end
                else spur++;
            end
            tick();
            i_req = ia; d_req = da;
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_wdata = 32'h0;
        i_vaddr = 32'h0000_0123; d_vaddr = 32'h0000_0456;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({i_rdata, d_rdata, mem_addr, mem_wdata, mem_be, i_ready, i_err, d_ready, d_err,
             mem_req, mem_we, bus_timeout_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got mem_req=%b i_ready=%b d_ready=%b mem_addr=%h want all zero",
                     mem_req, i_ready, d_ready, mem_addr);
        end
        n_checks++;
        if (mmu_vaddr !== 32'h0000_0123) begin
            n_fail++; $display("FAIL reset_mmu_vaddr_i: got %h want %h", mmu_vaddr, 32'h0000_0123);
        end
        d_req = 1'b1;
        #1;
        n_checks++;
        if (mmu_vaddr !== 32'h0000_0456 || stall_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_mmu_vaddr_d: got %h stall=%b want %h stall=1",
                               mmu_vaddr, stall_o, 32'h0000_0456);
        end
        d_req = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch();
        int ti, td, nreq, sb, sp, nt;
        logic ei, ed, tm;
        logic [31:0] ri, rd;
        bus_log.delete();
        i_vaddr = 32'h0000_1004; ack_wait = 2; no_ack = 1'b0; bus_rdata_val = 32'hDEAD_BEEF;
        fork
            run_access(1'b1, 1'b0, 20, ti, td, ei, ed, ri, rd, nreq, sb, sp, nt, tm);
            begin
                // remap after grant: the in-flight access must keep its translation
                @(negedge clk); @(negedge clk);
                map_offset = 32'h0080_0000;
            end
        join
        map_offset = MAP;
        n_checks++;
        if (ti !== 4) begin n_fail++; $display("FAIL fetch_latency: got %0d want 4", ti); end
        n_checks++;
        if (ei !== 1'b0 || ri !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL fetch_data: got err=%b data=%h want err=0 data=deadbeef", ei, ri);
        end
        n_checks++;
        if (bus_log.size() != 1) begin
            n_fail++; $display("FAIL fetch_bus_count: got %0d want 1", bus_log.size());
        end else if (bus_log[0].addr !== 32'h0040_1004 || bus_log[0].we !== 1'b0 || bus_log[0].be !== 4'hF) begin
            n_fail++; $display("FAIL fetch_bus: got addr=%h we=%b be=%h want 00401004/0/f",
                               bus_log[0].addr, bus_log[0].we, bus_log[0].be);
        end
        n_checks++;
        if (nreq != 3 || sb != 0 || sp != 0) begin
            n_fail++; $display("FAIL fetch_req_stall: got nreq=%0d stall_bad=%0d spur=%0d want 3/0/0", nreq, sb, sp);
        end
    endtask

    task automatic test_contention();
        int ti, td, nreq, sb, sp, nt;
        logic ei, ed, tm;
        logic [31:0] ri, rd;
        bus_log.delete();
        i_vaddr = 32'h0000_3000; d_vaddr = 32'h0000_2000;
        d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'h0000_ABCD;
        ack_wait = 0; bus_rdata_val = 32'h1111_2222;
        run_access(1'b1, 1'b1, 20, ti, td, ei, ed, ri, rd, nreq, sb, sp, nt, tm);
        n_checks++;
        if (td !== 2 || ti !== 5) begin
            n_fail++; $display("FAIL contention_latency: got d=%0d i=%0d want d=2 i=5", td, ti);
        end
        n_checks++;
        if (bus_log.size() != 2) begin
            n_fail++; $display("FAIL contention_bus_count: got %0d want 2", bus_log.size());
        end else if (bus_log[0].addr !== 32'h0040_2000 || bus_log[0].we !== 1'b1 ||
                     bus_log[0].be !== 4'b0011 || bus_log[0].wdata !== 32'h0000_ABCD ||
                     bus_log[1].addr !== 32'h0040_3000 || bus_log[1].we !== 1'b0) begin
            n_fail++; $display("FAIL contention_order: got %h/%b/%h/%h then %h/%b",
                               bus_log[0].addr, bus_log[0].we, bus_log[0].be, bus_log[0].wdata,
                               bus_log[1].addr, bus_log[1].we);
        end
        n_checks++;
        if (ed !== 1'b0 || ei !== 1'b0 || sb != 0 || sp != 0) begin
            n_fail++; $display("FAIL contention_flags: got ed=%b ei=%b stall_bad=%0d spur=%0d", ed, ei, sb, sp);
        end
        d_we = 1'b0;
    endtask

    task automatic test_fault();
        int ti, td, nreq, sb, sp, nt;
        logic ei, ed, tm;
        logic [31:0] ri, rd;
        bus_log.delete();
        d_vaddr = 32'hF000_0010; d_we = 1'b1; d_be = 4'hF; d_wdata = 32'h5555_AAAA;
        i_vaddr = 32'h0000_4000; ack_wait = 0; bus_rdata_val = 32'h3333_4444;
        run_access(1'b1, 1'b1, 20, ti, td, ei, ed, ri, rd, nreq, sb, sp, nt, tm);
        n_checks++;
        if (td !== 1 || ed !== 1'b1) begin
            n_fail++; $display("FAIL fault_d: got lat=%0d err=%b want lat=1 err=1", td, ed);
        end
        n_checks++;
        if (rd !== 32'h1111_2222) begin
            n_fail++; $display("FAIL fault_rdata_hold: got %h want 11112222", rd);
        end
        n_checks++;
        if (ti !== 4 || ei !== 1'b0 || ri !== 32'h3333_4444) begin
            n_fail++; $display("FAIL fault_i_after: got lat=%0d err=%b data=%h want 4/0/33334444", ti, ei, ri);
        end
        n_checks++;
        if (bus_log.size() != 1 || nreq != 1) begin
            n_fail++; $display("FAIL fault_no_bus: got transfers=%0d req_cycles=%0d want 1/1", bus_log.size(), nreq);
        end else if (bus_log[0].we !== 1'b0) begin
            n_fail++; $display("FAIL fault_no_bus: got write on bus want read only");
        end
        d_we = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        int ti, td, nreq, sb, sp, nt;
        logic ei, ed, tm;
        logic [31:0] ri, rd;
        bit saw_ready;
        d_vaddr = 32'h0000_6000; d_we = 1'b0; no_ack = 1'b1;
        d_req = 1'b1;
        tick();
        #2;
        n_checks++;
        if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_bus: got mem_req=%b want 1", mem_req); end
        clr = 1'b1;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || d_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_drop: got mem_req=%b d_ready=%b want 0/0", mem_req, d_ready);
        end
        saw_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (d_ready !== 1'b0 || i_ready !== 1'b0) saw_ready = 1'b1;
        end
        d_req = 1'b0;
        clr = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (d_ready !== 1'b0 || i_ready !== 1'b0) saw_ready = 1'b1;
        end
        n_checks++;
        if (saw_ready) begin n_fail++; $display("FAIL rstmid_no_ready: got ready pulse want none"); end
        n_checks++;
        if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata_cleared: got %h want 0", d_rdata); end
        tick();
        no_ack = 1'b0; ack_wait = 1; bus_rdata_val = 32'hCAFE_0001;
        run_access(1'b0, 1'b1, 20, ti, td, ei, ed, ri, rd, nreq, sb, sp, nt, tm);
        n_checks++;
        if (td !== 3 || ed !== 1'b0 || rd !== 32'hCAFE_0001) begin
            n_fail++; $display("FAIL rstmid_recover: got lat=%0d err=%b data=%h want 3/0/cafe0001", td, ed, rd);
        end
    endtask

    task automatic test_timeout();
        int ti, td, nreq, sb, sp, nt;
        logic ei, ed, tm;
        logic [31:0] ri, rd;
        d_vaddr = 32'h0000_7000; d_we = 1'b0;
`ifdef MEM_TIMEOUT_EN
        no_ack = 1'b1;
        run_access(1'b0, 1'b1, 20, ti, td, ei, ed, ri, rd, nreq, sb, sp, nt, tm);
        no_ack = 1'b0;
        n_checks++;
        if (td !== 5 || ed !== 1'b1 || nreq != 4) begin
            n_fail++; $display("FAIL timeout_abort: got lat=%0d err=%b req_cycles=%0d want 5/1/4", td, ed, nreq);
        end
        n_checks++;
        if (tm !== 1'b1 || nt != 1) begin
            n_fail++; $display("FAIL timeout_pulse: got at_ready=%b cycles=%0d want 1/1", tm, nt);
        end
        ack_wait = 3; bus_rdata_val = 32'h0BAD_F00D;
        run_access(1'b0, 1'b1, 20, ti, td, ei, ed, ri, rd, nreq, sb, sp, nt, tm);
        n_checks++;
        if (td !== 5 || ed !== 1'b0 || nt != 0 || rd !== 32'h0BAD_F00D) begin
            n_fail++; $display("FAIL timeout_ack_wins: got lat=%0d err=%b tmo=%0d data=%h want 5/0/0/0badf00d",
                               td, ed, nt, rd);
        end
`else
        ack_wait = 6; bus_rdata_val = 32'h0BAD_F00D;
        run_access(1'b0, 1'b1, 30, ti, td, ei, ed, ri, rd, nreq, sb, sp, nt, tm);
        n_checks++;
        if (td !== 8 || ed !== 1'b0 || nt != 0 || nreq != 7) begin
            n_fail++; $display("FAIL long_wait: got lat=%0d err=%b tmo=%0d req_cycles=%0d want 8/0/0/7",
                               td, ed, nt, nreq);
        end
`endif
    endtask

    task automatic test_back_to_back();
        localparam int N = 4;
        logic [31:0] vals[N+1];
        int k, done_i;
        foreach (vals[j]) vals[j] = $urandom();
        bus_log.delete();
        ack_wait = 0; d_we = 1'b0; i_vaddr = 32'h0000_8000;
        k = 0; done_i = 0;
        for (int c = 0; c < 40 && !done_i; c++) begin
            d_req = (k < N);
            d_vaddr = 32'h0000_5000 + 32'(16 * k);
            bus_rdata_val = vals[k];
            i_req = 1'b1;
            @(negedge clk);
            if (d_ready === 1'b1) begin
                n_checks++;
                if (k >= N || c != 2 + 3 * k || d_rdata !== vals[k]) begin
                    n_fail++; $display("FAIL b2b_d%0d: got cycle=%0d data=%h want cycle=%0d data=%h",
                                       k, c, d_rdata, 2 + 3 * k, vals[k]);
                end
                k++;
            end
            if (i_ready === 1'b1) begin
                n_checks++;
                if (c != 3 * N + 2 || i_rdata !== vals[N] || k != N) begin
                    n_fail++; $display("FAIL b2b_i_starve: got cycle=%0d data=%h want cycle=%0d data=%h",
                                       c, i_rdata, 3 * N + 2, vals[N]);
                end
                done_i = 1;
            end
            tick();
        end
        i_req = 1'b0; d_req = 1'b0;
        n_checks++;
        if (!done_i || k != N || bus_log.size() != N + 1) begin
            n_fail++; $display("FAIL b2b_complete: got i_done=%0d d_count=%0d transfers=%0d want 1/%0d/%0d",
                               done_i, k, bus_log.size(), N, N + 1);
        end else if (bus_log[N-1].addr !== 32'h0040_5030 || bus_log[N].addr !== 32'h0040_8000) begin
            n_fail++; $display("FAIL b2b_addr: got %h/%h want 00405030/00408000", bus_log[N-1].addr, bus_log[N].addr);
        end
    endtask

    task automatic test_random();
        int ti, td, nreq, sb, sp, nt;
        logic ei, ed, tm;
        logic [31:0] ri, rd, r;
        logic [31:0] m_i_rd, m_d_rd;
        int mode, w, li, ld, e_ti, e_td, e_nreq;
        bit fi, fd, ua, da;
        bus_t exp_q[$];
        clr = 1'b1;
        tick();
        @(negedge clk);
        clr = 1'b0;
        tick();
        m_i_rd = 32'h0; m_d_rd = 32'h0;
        for (int it = 0; it < 30; it++) begin
            mode = $urandom_range(0, 2);
            ua = (mode != 1); da = (mode != 0);
            fi = ($urandom_range(0, 4) == 0); fd = ($urandom_range(0, 4) == 0);
            r = $urandom(); i_vaddr = {fi ? 4'hF : 4'($urandom_range(0, 14)), r[27:0]};
            r = $urandom(); d_vaddr = {fd ? 4'hF : 4'($urandom_range(0, 14)), r[27:0]};
            d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom_range(1, 15)); d_wdata = $urandom();
            w = $urandom_range(0, 3); ack_wait = w; bus_rdata_val = $urandom();
            li = fi ? 1 : 2 + w; ld = fd ? 1 : 2 + w;
            e_td = da ? ld : -1;
            e_ti = !ua ? -1 : (da ? ld + 1 + li : li);
            e_nreq = 0;
            exp_q.delete();
            if (da && !fd) begin
                exp_q.push_back('{d_vaddr + MAP, d_we, d_be, d_wdata});
                e_nreq += 1 + w; m_d_rd = bus_rdata_val;
            end
            if (ua && !fi) begin
                exp_q.push_back('{i_vaddr + MAP, 1'b0, 4'hF, 32'h0});
                e_nreq += 1 + w; m_i_rd = bus_rdata_val;
            end
            bus_log.delete();
            run_access(ua, da, 30, ti, td, ei, ed, ri, rd, nreq, sb, sp, nt, tm);
            n_checks++;
            if (ti !== e_ti || td !== e_td) begin
                n_fail++; $display("FAIL rand%0d_latency: got i=%0d d=%0d want i=%0d d=%0d", it, ti, td, e_ti, e_td);
            end
            if (da) begin
                n_checks++;
                if (ed !== fd || rd !== m_d_rd) begin
                    n_fail++; $display("FAIL rand%0d_d: got err=%b data=%h want err=%b data=%h", it, ed, rd, fd, m_d_rd);
                end
            end
            if (ua) begin
                n_checks++;
                if (ei !== fi || ri !== m_i_rd) begin
                    n_fail++; $display("FAIL rand%0d_i: got err=%b data=%h want err=%b data=%h", it, ei, ri, fi, m_i_rd);
                end
            end
            n_checks++;
            if (bus_log.size() != exp_q.size() || nreq != e_nreq || sb != 0 || sp != 0 || nt != 0) begin
                n_fail++; $display("FAIL rand%0d_bus: got transfers=%0d req=%0d stall_bad=%0d spur=%0d tmo=%0d want %0d/%0d/0/0/0",
                                   it, bus_log.size(), nreq, sb, sp, nt, exp_q.size(), e_nreq);
            end else begin
                foreach (exp_q[j]) begin
                    n_checks++;
                    if (bus_log[j].addr !== exp_q[j].addr || bus_log[j].we !== exp_q[j].we ||
                        bus_log[j].be !== exp_q[j].be ||
                        (exp_q[j].we && bus_log[j].wdata !== exp_q[j].wdata)) begin
                        n_fail++; $display("FAIL rand%0d_xfer%0d: got %h/%b/%h/%h want %h/%b/%h/%h", it, j,
                                           bus_log[j].addr, bus_log[j].we, bus_log[j].be, bus_log[j].wdata,
                                           exp_q[j].addr, exp_q[j].we, exp_q[j].be, exp_q[j].wdata);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_fault();
        test_reset_mid_access();
        test_timeout();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
